sync_debounce: RTL and testbench



---
 rtl/sync_debounce_pkg.sv | 14 +
 rtl/sync_chain.sv | 23 ++
 rtl/sync_debounce.sv | 131 +++++++++++++
 tb/tb_sync_debounce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_debounce_pkg.sv
// rtl/sync_debounce_pkg.sv - shared types and default constants for the sync_debounce block
package sync_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_STABLE_CYCLES = 1000;
    localparam int DEF_HOLD_CYCLES   = 50000;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - async-clear flop chain for bringing an asynchronous input into the clk domain
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clear_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - synchronizer plus counter debouncer with rise/fall pulses; SYNC_DEBOUNCE_HOLD_EN adds long-high hold
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic clear_n,
    input  logic din,
    input  logic sample_tick,
    output logic q,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 ||
        longint'(STABLE_CYCLES) >= (longint'(1) << CNT_W) ||
        longint'(HOLD_CYCLES) >= (longint'(1) << CNT_W)) begin : g_param_check
        $error("sync_debounce: illegal parameter combination");
    end

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next, count_inc;
    logic             s;
    logic             accept;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_chain (
        .clk    (clk),
        .clear_n(clear_n),
        .d      (din),
        .q      (s)
    );

    assign count_inc = count + CNT_W'(1);

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        unique case (state)
            STABLE: begin
                count_next = '0;
                if (s != q && sample_tick) begin
                    if (STABLE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        count_next = CNT_W'(1);
                        state_next = SETTLING;
                    end
                end
            end
            SETTLING: begin
                // A single matching cycle rejects the glitch, tick or not.
                if (s == q) begin
                    count_next = '0;
                    state_next = STABLE;
                end else if (sample_tick) begin
                    if (count_inc == STABLE_MAX) begin
                        accept = 1'b1;
                    end else begin
                        count_next = count_inc;
                    end
                end
            end
            default: begin
                count_next = '0;
                state_next = STABLE;
            end
        endcase
        if (accept) begin
            count_next = '0;
            state_next = STABLE;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= STABLE;
            count <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                q <= s;
            end
            rise <= accept & s;
            fall <= accept & ~s;
        end
    end

`ifdef SYNC_DEBOUNCE_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] hold_count, hold_count_inc;
    logic             hold_flag;

    assign hold_count_inc = hold_count + CNT_W'(1);

    // Count stops once hold is set, so it saturates until q falls.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            hold_count <= '0;
            hold_flag  <= 1'b0;
        end else if (accept && !s) begin
            hold_count <= '0;
            hold_flag  <= 1'b0;
        end else if (q && sample_tick && !hold_flag) begin
            hold_count <= hold_count_inc;
            if (hold_count_inc == HOLD_MAX) begin
                hold_flag <= 1'b1;
            end
        end
    end

    assign hold = hold_flag;
`else
    assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// tb/tb_sync_debounce.sv - self-checking bench for sync_debounce: vector table, corner sequences, randomized model compare
module tb_sync_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int HOLDC  = 8;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    logic din = 1'b0;
    logic sample_tick = 1'b1;
    logic q, rise, fall, hold;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic d;
        logic t;
        logic eq;
        logic er;
        logic ef;
    } vec_t;

    vec_t vecs[$];

    // reference model state
    logic [SYNC-1:0] m_sync;
    int   run;
    int   hcnt;
    logic m_q, m_rise, m_fall, m_hold;

    always #5 clk = ~clk;

    sync_debounce #(
        .SYNC_STAGES  (SYNC),
        .CNT_W        (16),
        .STABLE_CYCLES(STABLE),
        .HOLD_CYCLES  (HOLDC)
    ) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .din        (din),
        .sample_tick(sample_tick),
        .q          (q),
        .rise       (rise),
        .fall       (fall),
        .hold       (hold)
    );

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0b want=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sync = '0;
        run    = 0;
        hcnt   = 0;
        m_q    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_hold = 1'b0;
    endtask

    // A new level is accepted after STABLE consecutive ticks of disagreement
    // between the synchronized input and q, with no agreeing cycle in between.
    task automatic model_edge(input logic d, input logic t);
        logic s_pre;
        logic q_old;
        s_pre  = m_sync[SYNC-1];
        q_old  = m_q;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s_pre == m_q) begin
            run = 0;
        end else if (t) begin
            run++;
            if (run == STABLE) begin
                m_q    = s_pre;
                run    = 0;
                m_rise = s_pre;
                m_fall = ~s_pre;
            end
        end
`ifdef SYNC_DEBOUNCE_HOLD_EN
        if (m_fall) begin
            hcnt   = 0;
            m_hold = 1'b0;
        end else if (q_old && t && !m_hold) begin
            hcnt++;
            if (hcnt == HOLDC) m_hold = 1'b1;
        end
`else
        if (q_old && t) hcnt++;
        m_hold = 1'b0;
`endif
        m_sync = {m_sync[SYNC-2:0], d};
    endtask

    task automatic step(input logic d, input logic t);
        din = d;
        sample_tick = t;
        @(posedge clk);
        cyc++;
        if (clear_n) model_edge(d, t);
        #1;
    endtask

    task automatic assert_reset();
        clear_n = 1'b0;
        #1;
        model_reset();
        check("reset_q", q, 1'b0);
        check("reset_rise", rise, 1'b0);
        check("reset_fall", fall, 1'b0);
        check("reset_hold", hold, 1'b0);
    endtask

    task automatic add(input logic d, input logic t, input logic eq, input logic er, input logic ef);
        vec_t v;
        v.d = d; v.t = t; v.eq = eq; v.er = er; v.ef = ef;
        vecs.push_back(v);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_q"}, q, m_q);
        check({tag, "_rise"}, rise, m_rise);
        check({tag, "_fall"}, fall, m_fall);
        check({tag, "_hold"}, hold, m_hold);
        if (rise && fall) check({tag, "_excl"}, 1'b1, 1'b0);
    endtask

    initial begin
        // clean rise: q at edge 6
        for (int i = 1; i <= 7; i++) add(1'b1, 1'b1, i >= 6, i == 6, 1'b0);
        // clean fall
        for (int i = 1; i <= 7; i++) add(1'b0, 1'b1, i < 6, 1'b0, i == 6);
        // glitch of 3 cycles is rejected
        for (int i = 1; i <= 9; i++) add(i <= 3, 1'b1, 1'b0, 1'b0, 1'b0);
        // exactly 4 cycles is accepted, then released
        for (int i = 1; i <= 11; i++)
            add(i <= 4, 1'b1, i >= 6 && i < 10, i == 6, i == 10);

        @(negedge clk);
        // reset held with din high: outputs stay low
        din = 1'b1;
        assert_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("rst_hold_q", q, 1'b0);
            check("rst_hold_rise", rise, 1'b0);
            check("rst_hold_hold", hold, 1'b0);
        end
        clear_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            check("rst_rel_q", q, i >= 6);
            check("rst_rel_rise", rise, i == 6);
        end

        // table vectors from q=0
        assert_reset();
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].d, vecs[i].t);
            check("tbl_q", q, vecs[i].eq);
            check("tbl_rise", rise, vecs[i].er);
            check("tbl_fall", fall, vecs[i].ef);
            check("tbl_hold", hold, 1'b0);
        end

        // tick every 3rd cycle: ticks at edges 3,6,9,12 -> accept at 12
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            step(1'b1, (i % 3) == 0);
            check("tick_q", q, i >= 12);
            check("tick_rise", rise, i == 12);
        end

        // reset mid-settle at count=3, then full requalification
        assert_reset();
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1);
            check("mid_pre_q", q, 1'b0);
        end
        assert_reset();
        clear_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b1);
            check("mid_req_q", q, i >= 6);
            check("mid_req_rise", rise, i == 6);
        end

        // long press: hold 8 ticks after rise, cleared with the fall
        assert_reset();
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 1; i <= 28; i++) begin
            step(i <= 20, 1'b1);
            check("long_q", q, i >= 6 && i < 26);
            check("long_fall", fall, i == 26);
`ifdef SYNC_DEBOUNCE_HOLD_EN
            check("long_hold", hold, i >= 14 && i < 26);
`else
            check("long_hold", hold, 1'b0);
`endif
        end

        // randomized compare against model
        assert_reset();
        clear_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic d;
            logic t;
            d = din;
            if ($urandom_range(0, 9) == 0) d = ~d;
            t = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) begin
                assert_reset();
                clear_n = 1'b1;
            end
            step(d, t);
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
